// File: rtl/updown_counter_gen_if.sv
// Control/status bundle for updown_counter_gen: the driver side (switches, controller)
// uses the master modport and the counter itself uses the slave modport.
interface updown_counter_gen_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             direction;
  logic             mode;
  logic [WIDTH-1:0] max_count;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             at_zero;
  logic             at_max;

  modport master (
    output enable, direction, mode, max_count, load, load_value,
    input  count, tc, at_zero, at_max
  );

  modport slave (
    input  enable, direction, mode, max_count, load, load_value,
    output count, tc, at_zero, at_max
  );
endinterface

// File: rtl/updown_counter_gen.sv
// Parametrised up/down counter with runtime maximum, wrap/saturate mode, load and a
// registered terminal-count pulse. Define COUNTER_PRESCALE_EN to step once per PRESCALE enabled clocks.
module updown_counter_gen #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input logic                  clock,
  input logic                  reset,
  updown_counter_gen_if.slave  bus
);

  if (WIDTH < 1 || PRESCALE < 1) begin : g_bad_param
    $error("updown_counter_gen: WIDTH and PRESCALE must be at least 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             step_due;

`ifdef COUNTER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] prescale_q;

  assign step_due = (prescale_q == PS_LAST);

  // Prescaler only counts enabled, non-load clocks so that enable gaps stretch the period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale_q <= '0;
    end else if (bus.load) begin
      prescale_q <= '0;
    end else if (bus.enable) begin
      prescale_q <= step_due ? '0 : prescale_q + 1'b1;
    end
  end
`else
  assign step_due = 1'b1;
`endif

  // Terminal checks come before +/-1, so the arithmetic never overflows WIDTH bits.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_value > bus.max_count) ? bus.max_count : bus.load_value;
    end else if (bus.enable && step_due) begin
      if (!bus.direction) begin
        if (count_q < bus.max_count) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d = bus.mode ? bus.max_count : '0;
          tc_d    = 1'b1;
        end
      end else begin
        if (count_q > bus.max_count) begin
          count_d = bus.max_count;
        end else if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          count_d = bus.mode ? '0 : bus.max_count;
          tc_d    = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.at_zero = (count_q == '0);
  assign bus.at_max  = (count_q == bus.max_count);

endmodule

// File: tb/tb_updown_counter_gen.sv
// Self-checking bench for updown_counter_gen: table vectors, corner-case sequences and
// randomized stimulus against a counting model; works with or without COUNTER_PRESCALE_EN.
module tb_updown_counter_gen;

  localparam int TW = 4;
`ifdef COUNTER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  updown_counter_gen_if #(.WIDTH(TW)) bus ();

  updown_counter_gen #(.WIDTH(TW), .PRESCALE(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: integer count plus number of enabled clocks since the last step/load.
  int m_count = 0;
  int m_tc    = 0;
  int m_ps    = 0;

  typedef struct {
    logic          ld;
    logic [TW-1:0] lv;
    logic          en;
    logic          dir;
    logic          md;
    logic [TW-1:0] mx;
    int            exp_count;
    int            exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic expect_out(input string tag, input int ec, input int et, input int mx);
    check({tag, " count"},   32'(bus.count),   32'(ec));
    check({tag, " tc"},      32'(bus.tc),      32'(et));
    check({tag, " at_zero"}, 32'(bus.at_zero), 32'(ec == 0));
    check({tag, " at_max"},  32'(bus.at_max),  32'(ec == mx));
  endtask

  task automatic model_clock();
    int mx;
    mx = int'(bus.max_count);
    if (reset) begin
      m_count = 0; m_tc = 0; m_ps = 0;
    end else if (bus.load) begin
      m_count = (int'(bus.load_value) < mx) ? int'(bus.load_value) : mx;
      m_tc = 0; m_ps = 0;
    end else if (bus.enable && (m_ps + 1 == PS)) begin
      m_ps = 0;
      m_tc = 0;
      if (!bus.direction) begin
        if (m_count < mx) m_count = m_count + 1;
        else begin m_count = bus.mode ? mx : 0; m_tc = 1; end
      end else begin
        if (m_count > mx)      m_count = mx;
        else if (m_count > 0)  m_count = m_count - 1;
        else begin m_count = bus.mode ? 0 : mx; m_tc = 1; end
      end
    end else begin
      if (bus.enable) m_ps = m_ps + 1;
      m_tc = 0;
    end
  endtask

  // One rising edge; the model sees the same inputs the DUT sampled, outputs are read 1ns later.
  task automatic tick();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic drive(input logic ld, input logic [TW-1:0] lv, input logic en,
                       input logic dir, input logic md, input logic [TW-1:0] mx);
    bus.load = ld; bus.load_value = lv; bus.enable = en;
    bus.direction = dir; bus.mode = md; bus.max_count = mx;
  endtask

  task automatic add(input logic ld, input logic [TW-1:0] lv, input logic en, input logic dir,
                     input logic md, input logic [TW-1:0] mx, input int ec, input int et);
    vec_t v;
    v.ld = ld; v.lv = lv; v.en = en; v.dir = dir; v.md = md; v.mx = mx;
    v.exp_count = ec; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  // Pulse reset between edges and confirm the outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    m_count = 0; m_tc = 0; m_ps = 0;
    expect_out({tag, " async"}, 0, 0, int'(bus.max_count));
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd5);
    tick();
    tick();
    reset = 1'b0;
    expect_out("reset", 0, 0, 5);

`ifndef COUNTER_PRESCALE_EN
    // Up wrap, max 5
    add(0, 0, 1, 0, 0, 5, 1, 0);
    add(0, 0, 1, 0, 0, 5, 2, 0);
    add(0, 0, 1, 0, 0, 5, 3, 0);
    add(0, 0, 1, 0, 0, 5, 4, 0);
    add(0, 0, 1, 0, 0, 5, 5, 0);
    add(0, 0, 1, 0, 0, 5, 0, 1);
    add(0, 0, 1, 0, 0, 5, 1, 0);
    add(0, 0, 0, 0, 0, 5, 1, 0);
    // Saturate down from load 3
    add(1, 3, 1, 1, 1, 5, 3, 0);
    add(0, 0, 1, 1, 1, 5, 2, 0);
    add(0, 0, 1, 1, 1, 5, 1, 0);
    add(0, 0, 1, 1, 1, 5, 0, 0);
    add(0, 0, 1, 1, 1, 5, 0, 1);
    add(0, 0, 1, 1, 1, 5, 0, 1);
    // Load clamp, then max lowered below count
    add(1, 12, 1, 0, 0, 9, 9, 0);
    add(0, 0, 1, 1, 0, 4, 4, 0);
    // Wrap down from zero
    add(1, 0, 1, 1, 0, 7, 0, 0);
    add(0, 0, 1, 1, 0, 7, 7, 1);
    // Zero range: every step terminal
    add(1, 5, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0, 0, 1);
    // Saturate up at full-width max
    add(1, 14, 0, 0, 1, 15, 14, 0);
    add(0, 0, 1, 0, 1, 15, 15, 0);
    add(0, 0, 1, 0, 1, 15, 15, 1);
    add(0, 0, 1, 0, 1, 15, 15, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].dir, vecs[i].md, vecs[i].mx);
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_tc, int'(vecs[i].mx));
    end
`else
    // Prescaler: 0 for three edges, 1 on the fourth enabled clock.
    for (int i = 1; i <= PS; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd15);
      tick();
      expect_out($sformatf("ps_first%0d", i), (i == PS) ? 1 : 0, 0, 15);
    end
    // Two enabled, two idle, two enabled: step lands on the 6th clock.
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, '0, (i == 3 || i == 4) ? 1'b0 : 1'b1, 1'b0, 1'b0, 4'd15);
      tick();
      expect_out($sformatf("ps_gap%0d", i), (i == 6) ? 2 : 1, 0, 15);
    end
    // Two enabled clocks, then load must restart the prescaler.
    for (int i = 1; i <= 2; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd15);
      tick();
    end
    drive(1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 4'd15);
    tick();
    expect_out("ps_load", 7, 0, 15);
    for (int i = 1; i <= PS; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd15);
      tick();
      expect_out($sformatf("ps_after_load%0d", i), (i == PS) ? 8 : 7, 0, 15);
    end
`endif

    // Async reset mid-count (and mid-prescale when present).
    drive(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 4'd15);
    tick();
    expect_out("pre_reset load", 6, 0, 15);
    for (int i = 0; i < ((PS > 2) ? 2 : PS - 1); i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd15);
      tick();
      expect_out($sformatf("pre_reset hold%0d", i), 6, 0, 15);
    end
    async_reset("midcount");
    expect_out("reset held", 0, 0, 15);
    for (int i = 1; i <= PS; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd15);
      tick();
      expect_out($sformatf("post_reset%0d", i), (i == PS) ? 1 : 0, 0, 15);
    end

    // Randomized run against the model.
    begin
      logic [TW-1:0] mx;
      mx = TW'($urandom_range(0, 15));
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 79) == 0) begin
          async_reset($sformatf("rnd%0d", i));
        end else begin
          if ($urandom_range(0, 15) == 0) mx = TW'($urandom_range(0, 15));
          drive(($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
                TW'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                mx);
          tick();
          expect_out($sformatf("rnd%0d", i), m_count, m_tc, int'(mx));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
